// File: rtl/lcd_ctrl_pkg.sv
// ------------------------------------------------------------------
// lcd_ctrl_pkg : command codes, issuer FSM states and helpers shared
//                by the LCD command issuer and its FIFO.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package lcd_ctrl_pkg;

  localparam int CMD_W = 4;

  localparam logic [CMD_W-1:0] CMD_WRITE       = 4'h0;
  localparam logic [CMD_W-1:0] CMD_SHIFT_UP    = 4'h1;
  localparam logic [CMD_W-1:0] CMD_SHIFT_DOWN  = 4'h2;
  localparam logic [CMD_W-1:0] CMD_SHIFT_LEFT  = 4'h3;
  localparam logic [CMD_W-1:0] CMD_SHIFT_RIGHT = 4'h4;
  localparam logic [CMD_W-1:0] CMD_MAX         = 4'h5;
  localparam logic [CMD_W-1:0] CMD_MIN         = 4'h6;
  localparam logic [CMD_W-1:0] CMD_AVG         = 4'h7;
  localparam logic [CMD_W-1:0] CMD_ROT_CCW     = 4'h8;
  localparam logic [CMD_W-1:0] CMD_ROT_CW      = 4'h9;
  localparam logic [CMD_W-1:0] CMD_MIRROR_X    = 4'hA;
  localparam logic [CMD_W-1:0] CMD_MIRROR_Y    = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_FINISHED  = 3'd5
  } issuer_state_t;

  // Codes above MIRROR_Y have no meaning to the controller.
  function automatic logic is_illegal_cmd(input logic [CMD_W-1:0] code);
    return (code > CMD_MIRROR_Y);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_cmd_fifo.sv
// ------------------------------------------------------------------
// lcd_cmd_fifo : synchronous FIFO, simultaneous push/pop, flush,
//                level/full/empty.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module lcd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == FULL_LEVEL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Flush has priority over any transfer in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        level_d = level_q + 1'b1;
      end else if (do_pop && !do_push) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/lcd_cmd_issuer.sv
// ------------------------------------------------------------------
// lcd_cmd_issuer : queues host commands and strobes them to the LCD
//                  controller one handshake at a time.  Optional
//                  ILLEGAL_FILTER_EN drops codes C-F (drop_cnt).  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module lcd_cmd_issuer
  import lcd_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 4,
  parameter int CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CMD_W-1:0]              in_cmd,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [CMD_W-1:0]              cmd,
  output logic                          cmd_valid,
  input  logic                          busy,
  input  logic                          done,
  input  logic                          clr,
  output logic                          seq_done,
  output logic                          ack_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              issued_cnt
`ifdef ILLEGAL_FILTER_EN
  ,
  output logic [CNT_W-1:0]              drop_cnt
`endif
);

  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  issuer_state_t    state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             ack_err_q, ack_err_d;
  logic             done_seen_q, done_seen_d;
  logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;

  logic             push_acc;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_head;

  assign in_ready = !fifo_full && (state_q != ST_FINISHED);
  assign push_acc = in_valid && in_ready;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (clr),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (in_cmd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

`ifdef ILLEGAL_FILTER_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             in_illegal;

  // Illegal codes are handshaken normally but never reach the FIFO.
  assign in_illegal = is_illegal_cmd(in_cmd);
  assign fifo_push  = push_acc && !in_illegal;
  assign drop_cnt   = drop_cnt_q;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      drop_cnt_d = '0;
    end else if (push_acc && in_illegal && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`else
  assign fifo_push = push_acc;
`endif

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    timer_d      = timer_q;
    ack_err_d    = ack_err_q;
    done_seen_d  = done_seen_q;
    issued_cnt_d = issued_cnt_q;
    fifo_pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A clear flushes the FIFO this cycle, so nothing may be popped.
        if (!fifo_empty && !busy && !clr) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_head;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d     = '0;
        done_seen_d = 1'b0;
        if (issued_cnt_q != {CNT_W{1'b1}}) begin
          issued_cnt_d = issued_cnt_q + 1'b1;
        end
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (busy) begin
          state_d = ST_WAIT_IDLE;
        end else if (timer_q == TMR_LAST) begin
          ack_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        // The controller may report done as busy falls; remember it.
        if (done) begin
          done_seen_d = 1'b1;
        end
        if (!busy) begin
          state_d = (cmd_q == CMD_WRITE) ? ST_WAIT_DONE : ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (done || done_seen_q) begin
          state_d = ST_FINISHED;
        end
      end
      ST_FINISHED: begin
        if (clr) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clr) begin
      ack_err_d    = 1'b0;
      issued_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      timer_q      <= '0;
      ack_err_q    <= 1'b0;
      done_seen_q  <= 1'b0;
      issued_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      timer_q      <= timer_d;
      ack_err_q    <= ack_err_d;
      done_seen_q  <= done_seen_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  assign cmd        = cmd_q;
  assign cmd_valid  = (state_q == ST_ISSUE);
  assign seq_done   = (state_q == ST_FINISHED);
  assign ack_err    = ack_err_q;
  assign issued_cnt = issued_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_cmd_issuer.sv
// ------------------------------------------------------------------
// tb_lcd_cmd_issuer : directed + randomized bench for lcd_cmd_issuer
//                     with a reactive LCD controller model.  Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_lcd_cmd_issuer;
  import lcd_ctrl_pkg::*;

  localparam int FIFO_DEPTH  = 8;
  localparam int ACK_TIMEOUT = 4;
  localparam int CNT_W       = 8;
  localparam int LW          = $clog2(FIFO_DEPTH) + 1;
`ifdef ILLEGAL_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       in_cmd;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       cmd;
  logic             cmd_valid;
  logic             busy;
  logic             done;
  logic             clr;
  logic             seq_done;
  logic             ack_err;
  logic [LW-1:0]    fifo_level;
  logic [CNT_W-1:0] issued_cnt;
`ifdef ILLEGAL_FILTER_EN
  logic [CNT_W-1:0] drop_cnt;
`endif

  logic force_busy = 1'b0;
  logic ctl_busy   = 1'b0;
  logic ctl_done   = 1'b0;
  assign busy = force_busy | ctl_busy;
  assign done = ctl_done;

  lcd_cmd_issuer #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_cmd     (in_cmd),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .busy       (busy),
    .done       (done),
    .clr        (clr),
    .seq_done   (seq_done),
    .ack_err    (ack_err),
    .fifo_level (fifo_level),
    .issued_cnt (issued_cnt)
`ifdef ILLEGAL_FILTER_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: commands expected on the strobe, in order.
  logic [3:0] exp_cmd[$];
  int         exp_issued = 0;
  int         exp_drop   = 0;

  // Observations from the interface.
  logic [3:0] obs_cmd[$];
  int         obs_cyc[$];
  int         dbl_cnt      = 0;
  int         peak_lvl     = 0;
  int         ack_rise_cyc = -1;
  logic       prev_valid   = 1'b0;
  logic       prev_ack     = 1'b0;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (cmd_valid === 1'b1) begin
        obs_cmd.push_back(cmd);
        obs_cyc.push_back(cyc);
      end
      if (cmd_valid === 1'b1 && prev_valid === 1'b1) dbl_cnt++;
      if (int'(fifo_level) > peak_lvl) peak_lvl = int'(fifo_level);
      if (ack_err === 1'b1 && prev_ack === 1'b0) ack_rise_cyc = cyc;
    end
    prev_valid = cmd_valid;
    prev_ack   = ack_err;
  end

  // LCD controller model: busy after each strobe, done after WRITE.
  bit ctl_rand    = 1'b0;
  int ctl_ignore_n = 0;
  int ign_total    = 0;
  always begin : controller
    bit         is_wr;
    int         d, l, dd;
    @(negedge clk);
    if (reset === 1'b0 && cmd_valid === 1'b1) begin
      if (ctl_ignore_n > 0) begin
        ctl_ignore_n--;
        ign_total++;
      end else begin
        is_wr = (cmd == CMD_WRITE);
        if (ctl_rand) begin
          d  = $urandom_range(1, 2);
          l  = $urandom_range(1, 4);
          dd = $urandom_range(0, 3);
        end else begin
          d = 1; l = 3; dd = 2;
        end
        repeat (d) @(negedge clk);
        ctl_busy = 1'b1;
        repeat (l) @(negedge clk);
        ctl_busy = 1'b0;
        if (is_wr) begin
          repeat (dd) @(negedge clk);
          ctl_done = 1'b1;
          @(negedge clk);
          ctl_done = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one push cycle; the model decides whether it must be taken.
  task automatic push(input logic [3:0] c, input bit expect_acc);
    bit acc;
    in_cmd   = c;
    in_valid = 1'b1;
    acc      = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    check("push_accept", acc, expect_acc);
    if (expect_acc) begin
      if (FILT && c >= 4'hC) begin
        exp_drop++;
      end else begin
        exp_cmd.push_back(c);
        exp_issued++;
      end
    end
  endtask

  task automatic wait_issued(input int n, input int budget);
    int k = 0;
    while (obs_cmd.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("strobe_count", obs_cmd.size(), n);
    repeat (14) @(negedge clk);
  endtask

  task automatic wait_seq_done(input int budget);
    int k = 0;
    while (seq_done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("seq_done_rise", seq_done, 1);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, obs_cmd.size(), exp_cmd.size());
    for (int i = 0; i < exp_cmd.size() && i < obs_cmd.size(); i++)
      check(tag, obs_cmd[i], exp_cmd[i]);
    obs_cmd.delete();
    obs_cyc.delete();
    exp_cmd.delete();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_issued = 0;
    exp_drop   = 0;
    ign_total  = 0;
  endtask

  initial begin : main
    logic [3:0] c;
    reset      = 1'b1;
    in_cmd     = 4'h0;
    in_valid   = 1'b0;
    clr        = 1'b0;
    force_busy = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_in_ready",   in_ready,   1);
    check("rst_cmd",        cmd,        0);
    check("rst_cmd_valid",  cmd_valid,  0);
    check("rst_seq_done",   seq_done,   0);
    check("rst_ack_err",    ack_err,    0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_issued",     issued_cnt, 0);
    reset = 1'b0;

    // Controller busy after reset: command waits.
    push(4'h1, 1'b1);
    repeat (20) @(negedge clk);
    check("busy_hold_strobes", obs_cmd.size(), 0);
    check("busy_hold_level", fifo_level, 1);
    force_busy = 1'b0;
    wait_issued(1, 50);
    check_seq("first_cmd");
    check("first_issued", issued_cnt, exp_issued);

    // Back-to-back pushes; first entry is popped as the second arrives.
    peak_lvl = 0;
    push(4'h1, 1'b1);
    push(4'h3, 1'b1);
    push(4'h5, 1'b1);
    push(4'h7, 1'b1);
    wait_issued(4, 100);
    for (int i = 1; i < 4 && i < obs_cyc.size(); i++)
      check("strobe_gap_ge5", (obs_cyc[i] - obs_cyc[i-1]) >= 5, 1);
    check("b2b_peak_level", peak_lvl, 3);
    check("b2b_level_end", fifo_level, 0);
    check_seq("b2b_order");
    check("b2b_issued", issued_cnt, exp_issued);

    // WRITE ends the sequence.
    push(4'h9, 1'b1);
    push(CMD_WRITE, 1'b1);
    wait_seq_done(100);
    check("fin_in_ready", in_ready, 0);
    check("fin_issued", issued_cnt, exp_issued);
    push(4'h2, 1'b0);
    check("fin_level", fifo_level, 0);
    check_seq("write_seq");
    pulse_clr();
    check("clr_seq_done", seq_done, 0);
    check("clr_issued", issued_cnt, 0);
    check("clr_in_ready", in_ready, 1);

    // Lost acknowledge: first strobe ignored, next still issues.
    ack_rise_cyc = -1;
    ctl_ignore_n = 1;
    push(4'h6, 1'b1);
    push(4'h2, 1'b1);
    wait_issued(2, 100);
    if (obs_cyc.size() > 0)
      check("ack_err_delay", ack_rise_cyc - obs_cyc[0], ACK_TIMEOUT + 1);
    check("ack_err_set", ack_err, 1);
    check("ack_issued", issued_cnt, exp_issued);
    check_seq("ack_seq");
    pulse_clr();
    check("clr_ack_err", ack_err, 0);
    check("clr_issued2", issued_cnt, 0);

    // Fill the FIFO while the controller is busy.
    force_busy = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      c = 4'($urandom_range(1, 11));
      push(c, 1'b1);
    end
    check("full_level", fifo_level, FIFO_DEPTH);
    check("full_in_ready", in_ready, 0);
    push(4'h3, 1'b0);
    force_busy = 1'b0;
    check("release_in_ready0", in_ready, 0);
    @(negedge clk);
    check("release_in_ready1", in_ready, 1);
    check("release_level", fifo_level, FIFO_DEPTH - 1);
    wait_issued(FIFO_DEPTH, 300);
    check_seq("fill_seq");
    check("fill_issued", issued_cnt, exp_issued);

    // Codes above MIRROR_Y.
    push(4'h2, 1'b1);
    push(4'hE, 1'b1);
    push(4'hF, 1'b1);
    push(4'h4, 1'b1);
    wait_issued(exp_cmd.size(), 200);
    check_seq("illegal_seq");
`ifdef ILLEGAL_FILTER_EN
    check("drop_cnt_dir", drop_cnt, exp_drop);
`endif

    // Randomized traffic with randomized controller timing.
    ctl_rand = 1'b1;
    repeat (40) begin
      if ($urandom_range(0, 7) == 0) ctl_ignore_n = 1;
      c = 4'($urandom_range(1, 15));
      if (exp_cmd.size() - obs_cmd.size() < FIFO_DEPTH) push(c, 1'b1);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_issued(exp_cmd.size(), 2000);
    ctl_ignore_n = 0;
    check("rand_ack_err", ack_err, ign_total > 0);
    check("rand_issued", issued_cnt, exp_issued);
`ifdef ILLEGAL_FILTER_EN
    check("rand_drop_cnt", drop_cnt, exp_drop);
`endif
    check_seq("rand_seq");

    push(CMD_WRITE, 1'b1);
    wait_seq_done(100);
    check_seq("rand_write");
    check("single_cycle_strobe", dbl_cnt, 0);
    pulse_clr();
    check("end_seq_done", seq_done, 0);
    check("end_level", fifo_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
